// File: rtl/datapath_seq_ctrl.sv
// Multi-cycle sequencer that turns one instruction word into register-file/ALU/RAM control strobes.
// Optional DPCTRL_EARLY_EXIT_EN: a repeat loop ends early when the ALU zero flag is set at write-back.
module datapath_seq_ctrl #(
   parameter int ALU_SEL_W = 5,
   parameter int REG_AW    = 5
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [31:0]          instr,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic [3:0]           status,
   output logic                 write,
   output logic [REG_AW-1:0]    writeReg,
   output logic [REG_AW-1:0]    readA,
   output logic [REG_AW-1:0]    readB,
   output logic [ALU_SEL_W-1:0] sel,
   output logic                 muxSel,
   output logic                 cin,
   output logic                 writeRam,
   output logic                 done,
   output logic                 err,
   output logic [3:0]           flags
);

   // state    | meaning
   // S_IDLE   | waiting for instruction, instr_ready high
   // S_DECODE | load repeat counter, pick NOP/illegal/work path
   // S_EXEC   | drive read addresses and ALU controls
   // S_WB     | hold controls, pulse write or writeRam, capture status
   // S_DONE   | one-cycle done pulse, err valid
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_WB     = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_ALU   = 3'd1;
   localparam logic [2:0] OP_ALUI  = 3'd2;
   localparam logic [2:0] OP_STORE = 3'd3;

   logic [2:0]  state;
   logic [2:0]  state_nxt;
   logic [31:0] ir;
   logic [7:0]  cnt;
   logic [2:0]  op;
   logic        illegal;
   logic        active;
   logic        stop_early;
   logic        accept;

   assign op      = ir[31:29];
   assign illegal = op[2];
   assign active  = (state == S_EXEC) || (state == S_WB);
   assign accept  = (state == S_IDLE) && instr_valid;

`ifdef DPCTRL_EARLY_EXIT_EN
   assign stop_early = status[0];
`else
   assign stop_early = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (instr_valid) state_nxt = S_DECODE;
         S_DECODE: state_nxt = (op == OP_NOP || illegal) ? S_DONE : S_EXEC;
         S_EXEC:   state_nxt = S_WB;
         S_WB:     state_nxt = (cnt != 8'd0 && !stop_early) ? S_EXEC : S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         ir    <= 32'd0;
         cnt   <= 8'd0;
         flags <= 4'd0;
      end else begin
         state <= state_nxt;
         if (accept) ir <= instr;
         if (state == S_DECODE) cnt <= ir[7:0];
         if (state == S_WB) begin
            flags <= status;
            // counter stops at zero: the zero case exits the loop instead of wrapping
            if (cnt != 8'd0 && !stop_early) cnt <= cnt - 8'd1;
         end
      end
   end

   assign instr_ready = (state == S_IDLE);
   assign done        = (state == S_DONE);
   assign err         = done && illegal;

   assign readA    = active ? REG_AW'(ir[23:19])   : '0;
   assign readB    = active ? REG_AW'(ir[18:14])   : '0;
   assign writeReg = active ? REG_AW'(ir[28:24])   : '0;
   assign sel      = active ? ALU_SEL_W'(ir[13:9]) : '0;
   assign cin      = active && ir[8];
   assign muxSel   = active && (op == OP_ALUI);
   assign write    = (state == S_WB) && (op == OP_ALU || op == OP_ALUI);
   assign writeRam = (state == S_WB) && (op == OP_STORE);

endmodule

// File: doc/datapath_seq_ctrl.md
# datapath_seq_ctrl

Multi-cycle control sequencer that drives the register-file/ALU/RAM datapath's control inputs from a 32-bit instruction word. It accepts one instruction per valid/ready handshake, sequences register reads, ALU operation and register or RAM write-back, and optionally repeats the ALU step under a loop counter. It returns a done pulse with the captured ALU status. It sits between the instruction source (test harness or future fetch unit) and the datapath control port.

## Interface
- ALU_SEL_W, 5, width of ALU function select
- REG_AW, 5, register address width
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- instr  in  32  instruction: [31:29] op, [28:24] rd, [23:19] ra, [18:14] rb, [13:9] alu sel, [8] cin, [7:0] repeat count N
- instr_valid  in  1  instruction present
- instr_ready  out  1  high only in IDLE
- status  in  4  datapath ALU status; bit 0 = zero flag
- write  out  1  register-file write enable
- writeReg  out  REG_AW  destination register / 5-bit immediate
- readA, readB  out  REG_AW  register read addresses
- sel  out  ALU_SEL_W  ALU function
- muxSel  out  1  1 = operand A from writeReg (immediate)
- cin  out  1  ALU carry-in
- writeRam  out  1  RAM write enable
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: illegal opcode
- flags  out  4  status captured at last write-back

## Operation
- Opcodes: 000 NOP; 001 ALU (rd <= ra op rb); 010 ALUI (rd <= imm(rd field) op rb, muxSel=1); 011 STORE (RAM[alu_out[7:0]] <= reg[ra], address computed from ra op rb); 100–111 illegal.
- States: IDLE, DECODE, EXEC, WB, DONE.
- IDLE: instr_ready=1; instr_valid & instr_ready latches instr -> DECODE.
- DECODE: load repeat counter with N; NOP -> DONE; illegal -> DONE with err=1; else -> EXEC.
- EXEC: drive readA=ra, readB=rb, sel, cin, writeReg=rd, muxSel (1 for ALUI); write=writeRam=0.
- WB: hold all EXEC outputs; assert write (ALU/ALUI) or writeRam (STORE) for exactly this cycle; capture status into flags.
- After WB: counter≠0 -> decrement, EXEC; counter=0 -> DONE.
- Repeat semantics: op executed N+1 times; with rd=ra, accumulates (e.g. rd += rb each pass).
- DONE: done=1 one cycle, err valid; -> IDLE.
- All control outputs 0 outside EXEC/WB; flags hold until next WB.

## Timing
- Reset (async assert, sync release): state IDLE, instr_ready=1; write, writeRam, done, err, muxSel, cin = 0; writeReg, readA, readB, sel, flags = 0; counter=0.
- Accept on edge k -> DECODE in cycle k+1, EXEC k+2, WB k+3, done in k+4; instr_ready high again in k+5.
- Each extra repeat adds 2 cycles; N=255 -> 256 passes, done at k+2+512.
- NOP/illegal: done in k+2.
- instr_valid ignored while instr_ready=0; instr changes during execution have no effect.
- Reset mid-operation: write/writeRam drop immediately; partial loop abandoned; no done.
- Counter 8-bit; decrement never wraps (exit at 0).

## Configuration
- DPCTRL_EARLY_EXIT_EN defined: after WB, if status[0]=1 and counter≠0, go to DONE instead of EXEC (loop terminates on zero result); flags reflect that WB.
- Undefined: status[0] ignored for sequencing; always N+1 passes.

## Test plan
- Reset asserted mid-WB of ALU op -> write falls within same cycle, all outputs 0, instr_ready=1 after release.
- ALU op=001, rd=3, ra=1, rb=2, sel=5, cin=1, N=0 -> EXEC then WB with readA=1, readB=2, sel=5, cin=1, write=1 for one cycle; done 4 cycles after accept; flags = status sampled in WB.
- ALUI rd=7 -> muxSel=1, writeReg=7 in EXEC and WB; write=1 only in WB.
- STORE ra=4, rb=6 -> writeRam=1 for one cycle, write=0 throughout.
- ALU N=3, rd=ra=1 -> exactly 4 write pulses, done at accept+10; with DPCTRL_EARLY_EXIT_EN and status[0]=1 on 2nd WB -> 2 write pulses, done at accept+6.
- op=101 -> done and err=1 at accept+2, no write/writeRam; instr_valid held high during busy -> no second accept until IDLE.
